// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and special cases resolved in the FINISH cycle.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] Data1,
    input  logic [XLEN-1:0] Data2,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t              state_q, state_d;
    logic [2:0]          func3_q, func3_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                sign1_q, sign1_d;
    logic                sign2_q, sign2_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d;

    logic                signed1_in, signed2_in;
    logic                neg1_in, neg2_in;
    logic [XLEN-1:0]     mag1_in, mag2_in;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_trial;
    logic                div_ge;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo, rem;

    // Operand signedness from func3: MULHSU treats only rs1 as signed.
    always_comb begin
        signed1_in = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
        signed2_in = func3[2] ? ~func3[0] : ~func3[1];
        neg1_in    = signed1_in & Data1[XLEN-1];
        neg2_in    = signed2_in & Data2[XLEN-1];
        mag1_in    = neg1_in ? (~Data1 + 1'b1) : Data1;
        mag2_in    = neg2_in ? (~Data2 + 1'b1) : Data2;
    end

    // acc holds {high product, remaining multiplier} or {partial remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        div_ge    = ~div_trial[XLEN];
        div_next  = {(div_ge ? div_trial[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1]),
                     acc_q[XLEN-2:0], div_ge};
        prod_s    = (sign1_q ^ sign2_q) ? (~acc_q + 1'b1) : acc_q;
        quo       = acc_q[XLEN-1:0];
        rem       = acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        func3_d  = func3_q;
        a_d      = a_q;
        b_d      = b_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    func3_d = func3;
                    a_d     = mag1_in;
                    b_d     = mag2_in;
                    sign1_d = neg1_in;
                    sign2_d = neg2_in;
                    acc_d   = func3[2] ? {{XLEN{1'b0}}, mag1_in} : {{XLEN{1'b0}}, mag2_in};
                    count_d = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = func3_q[2] ? div_next : mul_next;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(XLEN - 1)) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                case (func3_q)
                    3'b000:                 result_d = prod_s[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_s[2*XLEN-1:XLEN];
                    3'b100, 3'b101:
                        result_d = (b_q == '0) ? {XLEN{1'b1}} :
                                   ((sign1_q ^ sign2_q) ? (~quo + 1'b1) : quo);
                    default:
                        // Divide-by-zero remainder returns rs1, rebuilt from its magnitude.
                        result_d = (b_q == '0) ? (sign1_q ? (~a_q + 1'b1) : a_q) :
                                   (sign1_q ? (~rem + 1'b1) : rem);
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            func3_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            func3_q  <= func3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Busy is combinational so the upstream stall lands in the Start cycle itself.
    assign Busy   = ((state_q == S_IDLE) && Start && !Flush) || (state_q == S_CALC);
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M corner cases plus random ops
// checked against an arithmetic reference model, with latency and Busy checks.
module tb_ex_muldiv_unit;
    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] Data1 = 32'd0;
    logic [31:0] Data2 = 32'd0;
    logic        Flush = 1'b0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .func3(func3),
        .Data1(Data1), .Data2(Data2), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic and SV division semantics.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb64, ub;
        logic [63:0]        p;
        int                 ia, ib;
        sa   = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub   = {32'd0, b};
        ia   = a;
        ib   = b;
        case (f)
            3'd0: begin p = sa * sb64; return p[31:0]; end
            3'd1: begin p = sa * sb64; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (Reset && Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 result %h, expected no Done", Result);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " result"}, Result, mon_e.res);
                check({mon_e.name, " latency"}, 32'(cyc), 32'(mon_e.done_cyc));
                last_res = mon_e.res;
                $display("txn %-12s result=%h expected=%h cycle=%0d", mon_e.name, Result,
                         mon_e.res, cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] req, input string nm);
        @(negedge CLK);
        Start = 1'b1; func3 = f; Data1 = a; Data2 = b;
        #1;
        check({nm, " busy_at_start"}, {31'd0, Busy}, 32'd1);
        sb.push_back('{req, cyc + 34, nm});
        @(negedge CLK);
        Start = 1'b0; func3 = 3'($urandom); Data1 = $urandom; Data2 = $urandom;
    endtask

    task automatic wait_done(input string nm, output int busy_cnt);
        int n;
        busy_cnt = 0;
        n = 0;
        while (1) begin
            #1;
            if (sb.size() == 0) break;
            if (Busy) busy_cnt++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got no Done after %0d cycles, expected Done", nm, n);
                sb.delete();
                break;
            end
            n++;
            @(negedge CLK);
        end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        string       nm;
    } dir_t;

    dir_t dirs[$];
    int   bc;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    initial begin
        dirs = '{
            '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL"},
            '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "MULH"},
            '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU"},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU"},
            '{3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, "DIV"},
            '{3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, "REM"},
            '{3'd5, 32'd100,        32'd7,         32'd14,        "DIVU"},
            '{3'd7, 32'd100,        32'd7,         32'd2,         "REMU"},
            '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIV_by0"},
            '{3'd6, 32'd5,          32'd0,         32'd5,         "REM_by0"},
            '{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "DIVneg_by0"},
            '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "REMneg_by0"},
            '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIVU_by0"},
            '{3'd7, 32'd5,          32'd0,         32'd5,         "REMU_by0"},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV_ovf"},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "REM_ovf"}
        };

        repeat (3) @(negedge CLK);
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset done", {31'd0, Done}, 32'd0);
        check("reset result", Result, 32'd0);
        Reset = 1'b1;

        foreach (dirs[i]) begin
            issue(dirs[i].f, dirs[i].a, dirs[i].b, dirs[i].r, dirs[i].nm);
            wait_done(dirs[i].nm, bc);
            if (i == 0) check("MUL busy_cycles", 32'(bc), 32'd32);
        end

        // Start pulses while busy must not be queued.
        issue(3'd0, 32'd11, 32'd13, 32'd143, "MUL_ign");
        repeat (5) @(negedge CLK);
        Start = 1'b1; func3 = 3'd5; Data1 = 32'd99; Data2 = 32'd9;
        repeat (2) @(negedge CLK);
        Start = 1'b0;
        wait_done("MUL_ign", bc);
        repeat (40) @(negedge CLK);

        // Flush mid-CALC: no Done, Result holds.
        issue(3'd5, 32'd1000, 32'd10, 32'd100, "DIVU_flush");
        repeat (10) @(negedge CLK);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        void'(sb.pop_back());
        #1;
        check("flush busy", {31'd0, Busy}, 32'd0);
        check("flush result_hold", Result, last_res);
        repeat (40) @(negedge CLK);
        check("flush result_after", Result, last_res);

        // Flush wins over Start in IDLE.
        @(negedge CLK);
        Start = 1'b1; Flush = 1'b1; func3 = 3'd0; Data1 = 32'd3; Data2 = 32'd3;
        #1;
        check("flush_start busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        Start = 1'b0; Flush = 1'b0;
        repeat (40) @(negedge CLK);
        check("flush_start result", Result, last_res);

        // Start in FINISH ignored; re-asserted in the next cycle is accepted.
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0),
              "MULHU_b2b1");
        repeat (32) @(negedge CLK);
        Start = 1'b1; func3 = 3'd7; Data1 = 32'd1234567; Data2 = 32'd1000;
        #1;
        check("finish busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        #1;
        check("b2b busy_at_start", {31'd0, Busy}, 32'd1);
        sb.push_back('{32'd567, cyc + 34, "REMU_b2b2"});
        @(negedge CLK);
        Start = 1'b0;
        wait_done("REMU_b2b2", bc);

        // Asynchronous reset mid-CALC aborts with no Done.
        issue(3'd0, 32'd9, 32'd9, 32'd81, "MUL_rst");
        repeat (10) @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("midop reset busy", {31'd0, Busy}, 32'd0);
        check("midop reset result", Result, 32'd0);
        check("midop reset done", {31'd0, Done}, 32'd0);
        sb.delete();
        last_res = 32'd0;
        @(negedge CLK);
        Reset = 1'b1;
        repeat (40) @(negedge CLK);
        check("post reset result", Result, 32'd0);

        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 100));
            issue(rf, ra, rb, ref_model(rf, ra, rb), $sformatf("rnd%0d_f%0d", i, rf));
            wait_done("rnd", bc);
        end

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
